// File: rtl/ball_split_controller.sv
// Tracks a full binary tree of splitting balls: deploys the root, splits hit balls into their children,
// and reports pops, remaining balls and level clearance to the game controller.
module ball_split_controller #(
    parameter  int LEVELS    = 3,
    localparam int NUM_BALLS = (1 << LEVELS) - 1,
    localparam int CW        = $clog2(NUM_BALLS + 1)
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 unitActive,
    input  logic [NUM_BALLS-1:0] col_rope_ball_vec,
    input  logic [NUM_BALLS-1:0] col_player_ball_vec,
    output logic [NUM_BALLS-1:0] ballVisible,
    output logic                 col_rope_ball,
    output logic                 col_player_ball,
    output logic                 popValid,
    output logic [CW-1:0]        popCount,
    output logic [CW-1:0]        ballsRemaining,
    output logic                 allCleared
);

    // Balls below this index have children; the rest are leaves that simply vanish.
    localparam int NUM_PARENTS = (1 << (LEVELS - 1)) - 1;
    localparam logic [NUM_BALLS-1:0] ROOT_ONLY = NUM_BALLS'(1'b1);
    localparam logic [NUM_BALLS-1:0] NO_BALLS  = {NUM_BALLS{1'b0}};

    typedef enum logic [1:0] {
        INACTIVE = 2'd0,
        DEPLOY   = 2'd1,
        ACTIVE   = 2'd2,
        CLEARED  = 2'd3
    } state_t;

    state_t               state_r;
    state_t               stateNext_s;
    logic [NUM_BALLS-1:0] visible_r;
    logic [NUM_BALLS-1:0] visNext_s;
    logic [NUM_BALLS-1:0] hit_s;
    logic [NUM_BALLS-1:0] childSet_s;
    logic                 popValid_r;
    logic                 popValidNext_s;
    logic [CW-1:0]        popCount_r;
    logic [CW-1:0]        popCountNext_s;
    logic [CW-1:0]        remaining_r;
    logic                 cleared_r;

    function automatic logic [CW-1:0] popCnt(input logic [NUM_BALLS-1:0] v);
        logic [CW-1:0] cnt;
        cnt = {CW{1'b0}};
        for (int i = 0; i < NUM_BALLS; i++) begin
            cnt = cnt + CW'(v[i]);
        end
        return cnt;
    endfunction

    assign hit_s = col_rope_ball_vec & visible_r;

    // Children of every hit parent become visible next cycle.
    always_comb begin
        childSet_s = NO_BALLS;
        for (int i = 0; i < NUM_PARENTS; i++) begin
            if (hit_s[i]) begin
                childSet_s[2*i+1] = 1'b1;
                childSet_s[2*i+2] = 1'b1;
            end else begin
                childSet_s[2*i+1] = childSet_s[2*i+1];
            end
        end
    end

    // Next-state, next-visibility and pop reporting.
    always_comb begin
        stateNext_s    = state_r;
        visNext_s      = visible_r;
        popValidNext_s = 1'b0;
        popCountNext_s = {CW{1'b0}};
        case (state_r)
            INACTIVE: begin
                visNext_s = NO_BALLS;
                if (unitActive) begin
                    stateNext_s = DEPLOY;
                end else begin
                    stateNext_s = INACTIVE;
                end
            end
            DEPLOY: begin
                visNext_s   = ROOT_ONLY;
                stateNext_s = ACTIVE;
            end
            ACTIVE: begin
                if (!unitActive) begin
                    visNext_s   = NO_BALLS;
                    stateNext_s = INACTIVE;
                end else begin
                    // Clear wins over set should both ever target the same ball.
                    visNext_s      = (visible_r | childSet_s) & ~hit_s;
                    popValidNext_s = |hit_s;
                    popCountNext_s = popCnt(hit_s);
                    if (visible_r == NO_BALLS) begin
                        stateNext_s = CLEARED;
                    end else begin
                        stateNext_s = ACTIVE;
                    end
                end
            end
            CLEARED: begin
                visNext_s = NO_BALLS;
                if (!unitActive) begin
                    stateNext_s = INACTIVE;
                end else begin
                    stateNext_s = CLEARED;
                end
            end
            default: begin
                visNext_s   = NO_BALLS;
                stateNext_s = INACTIVE;
            end
        endcase
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_r     <= INACTIVE;
            visible_r   <= NO_BALLS;
            popValid_r  <= 1'b0;
            popCount_r  <= {CW{1'b0}};
            remaining_r <= {CW{1'b0}};
            cleared_r   <= 1'b0;
        end else begin
            state_r     <= stateNext_s;
            visible_r   <= visNext_s;
            popValid_r  <= popValidNext_s;
            popCount_r  <= popCountNext_s;
            remaining_r <= popCnt(visNext_s);
            cleared_r   <= (stateNext_s == CLEARED);
        end
    end

    assign ballVisible     = visible_r;
    assign popValid        = popValid_r;
    assign popCount        = popCount_r;
    assign ballsRemaining  = remaining_r;
    assign allCleared      = cleared_r;
    assign col_rope_ball   = |(col_rope_ball_vec & visible_r);
    assign col_player_ball = |(col_player_ball_vec & visible_r);

endmodule

// File: tb/tb_ball_split_controller.sv
// Directed bench for ball_split_controller (LEVELS=3): expected register values are queued when
// stimulus is applied and compared after the following clock edge.
module tb_ball_split_controller;

    logic       clk;
    logic       resetN;
    logic       unitActive;
    logic [6:0] col_rope_ball_vec;
    logic [6:0] col_player_ball_vec;
    logic [6:0] ballVisible;
    logic       col_rope_ball;
    logic       col_player_ball;
    logic       popValid;
    logic [2:0] popCount;
    logic [2:0] ballsRemaining;
    logic       allCleared;

    int nVec = 0;
    int nErr = 0;

    typedef struct packed {
        logic [6:0] vis;
        logic       pv;
        logic [2:0] pc;
        logic [2:0] rem;
        logic       clr;
    } exp_t;

    exp_t sbQ[$];

    ball_split_controller #(.LEVELS(3)) dut (
        .clk                 (clk),
        .resetN              (resetN),
        .unitActive          (unitActive),
        .col_rope_ball_vec   (col_rope_ball_vec),
        .col_player_ball_vec (col_player_ball_vec),
        .ballVisible         (ballVisible),
        .col_rope_ball       (col_rope_ball),
        .col_player_ball     (col_player_ball),
        .popValid            (popValid),
        .popCount            (popCount),
        .ballsRemaining      (ballsRemaining),
        .allCleared          (allCleared)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [6:0] vis, input logic pv, input logic [2:0] pc,
                                input logic [2:0] rem, input logic clr);
        exp_t e;
        e.vis = vis; e.pv = pv; e.pc = pc; e.rem = rem; e.clr = clr;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nVec++;
        assert (obs === expv) else begin
            nErr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Queue the expectation for the next edge, then compare once the DUT has updated.
    task automatic cycle(input string tag, input exp_t e);
        exp_t got;
        sbQ.push_back(e);
        @(posedge clk);
        #1;
        got = sbQ.pop_front();
        chk({tag, ".vis"}, 32'(ballVisible), 32'(got.vis));
        chk({tag, ".pv"},  32'(popValid), 32'(got.pv));
        chk({tag, ".pc"},  32'(popCount), 32'(got.pc));
        chk({tag, ".rem"}, 32'(ballsRemaining), 32'(got.rem));
        chk({tag, ".clr"}, 32'(allCleared), 32'(got.clr));
    endtask

    task automatic drive(input logic ua, input logic [6:0] rope, input logic [6:0] player);
        unitActive          = ua;
        col_rope_ball_vec   = rope;
        col_player_ball_vec = player;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        resetN = 1'b0;
        drive(1'b1, 7'($urandom), 7'($urandom));
        @(posedge clk);
        #1;
        // Reset with random collisions
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 7'($urandom), 7'($urandom));
            cycle("reset", mk(7'b0000000, 1'b0, 3'd0, 3'd0, 1'b0));
        end
        resetN = 1'b1;
        drive(1'b0, 7'b0000000, 7'b0000000);
        cycle("idle", mk(7'b0000000, 1'b0, 3'd0, 3'd0, 1'b0));
        cycle("idle2", mk(7'b0000000, 1'b0, 3'd0, 3'd0, 1'b0));

        // Deploy
        drive(1'b1, 7'b0000000, 7'b0000000);
        cycle("deploy", mk(7'b0000000, 1'b0, 3'd0, 3'd0, 1'b0));
        cycle("active", mk(7'b0000001, 1'b0, 3'd0, 3'd1, 1'b0));

        // Split root
        drive(1'b1, 7'b0000001, 7'b0000000);
        #1;
        chk("ropeRoot", 32'(col_rope_ball), 32'd1);
        cycle("split", mk(7'b0000110, 1'b1, 3'd1, 3'd2, 1'b0));
        drive(1'b1, 7'b0000000, 7'b0000000);
        cycle("splitHold", mk(7'b0000110, 1'b0, 3'd0, 3'd2, 1'b0));

        // Invisible ball hit is masked; player collisions are forwarded only
        drive(1'b1, 7'b0100000, 7'b0100000);
        #1;
        chk("ropeMask", 32'(col_rope_ball), 32'd0);
        chk("playerMask", 32'(col_player_ball), 32'd0);
        cycle("maskHold", mk(7'b0000110, 1'b0, 3'd0, 3'd2, 1'b0));
        drive(1'b1, 7'b0000000, 7'b0000100);
        #1;
        chk("playerHit", 32'(col_player_ball), 32'd1);
        cycle("playerHold", mk(7'b0000110, 1'b0, 3'd0, 3'd2, 1'b0));

        // Simultaneous sibling hits
        drive(1'b1, 7'b0000110, 7'b0000000);
        #1;
        chk("ropeSib", 32'(col_rope_ball), 32'd1);
        cycle("sibs", mk(7'b1111000, 1'b1, 3'd2, 3'd4, 1'b0));

        // Mixed: one leaf alone, then the remaining three
        drive(1'b1, 7'b0001000, 7'b0000000);
        cycle("leaf3", mk(7'b1110000, 1'b1, 3'd1, 3'd3, 1'b0));
        drive(1'b1, 7'b1111111, 7'b0000000);
        cycle("clear", mk(7'b0000000, 1'b1, 3'd3, 3'd0, 1'b0));
        drive(1'b1, 7'b0000000, 7'b0000000);
        cycle("cleared", mk(7'b0000000, 1'b0, 3'd0, 3'd0, 1'b1));
        drive(1'b1, 7'b1111111, 7'b1111111);
        #1;
        chk("ropeCleared", 32'(col_rope_ball), 32'd0);
        cycle("clearedHold", mk(7'b0000000, 1'b0, 3'd0, 3'd0, 1'b1));
        drive(1'b0, 7'b0000000, 7'b0000000);
        cycle("uncleared", mk(7'b0000000, 1'b0, 3'd0, 3'd0, 1'b0));

        // Abort mid-game with a simultaneous hit
        drive(1'b1, 7'b0000000, 7'b0000000);
        cycle("deploy2", mk(7'b0000000, 1'b0, 3'd0, 3'd0, 1'b0));
        cycle("active2", mk(7'b0000001, 1'b0, 3'd0, 3'd1, 1'b0));
        drive(1'b1, 7'b0000001, 7'b0000000);
        cycle("split2", mk(7'b0000110, 1'b1, 3'd1, 3'd2, 1'b0));
        drive(1'b0, 7'b0000010, 7'b0000000);
        cycle("abort", mk(7'b0000000, 1'b0, 3'd0, 3'd0, 1'b0));
        drive(1'b1, 7'b0000000, 7'b0000000);
        cycle("redeploy", mk(7'b0000000, 1'b0, 3'd0, 3'd0, 1'b0));
        cycle("reactive", mk(7'b0000001, 1'b0, 3'd0, 3'd1, 1'b0));

        // Reset mid-game with a pending hit
        drive(1'b1, 7'b0000001, 7'b0000000);
        cycle("split3", mk(7'b0000110, 1'b1, 3'd1, 3'd2, 1'b0));
        resetN = 1'b0;
        drive(1'b1, 7'b0000010, 7'b0000000);
        cycle("midReset", mk(7'b0000000, 1'b0, 3'd0, 3'd0, 1'b0));
        resetN = 1'b1;
        drive(1'b0, 7'b0000000, 7'b0000000);
        cycle("postReset", mk(7'b0000000, 1'b0, 3'd0, 3'd0, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule

// File: doc/ball_split_controller.md
Name: ball_split_controller

Overview:
Parametrised successor of the fixed three-ball controller. It tracks a full binary tree of balls of depth LEVELS. Ball 0 is the root; ball i splits into balls 2i+1 and 2i+2 when hit by the rope, and leaf balls simply vanish. It sits between the per-ball collision detectors and the ball drawers/game controller, and it adds pop counting, a remaining-balls count and a level-cleared indication.

Parameters:
LEVELS, 3, tree depth (minimum 1); NUM_BALLS = 2^LEVELS - 1 (7 at default).
CW, $clog2(NUM_BALLS+1), derived width of the count outputs (3 at default).

Ports:
clk  in  1  system clock
resetN  in  1  reset, synchronous, active-low
unitActive  in  1  game level running
col_rope_ball_vec  in  NUM_BALLS  per-ball rope collision, bit i = ball i
col_player_ball_vec  in  NUM_BALLS  per-ball player collision
ballVisible  out  NUM_BALLS  registered visibility, bit i = ball i
col_rope_ball  out  1  combinational OR of (col_rope_ball_vec & ballVisible)
col_player_ball  out  1  combinational OR of (col_player_ball_vec & ballVisible)
popValid  out  1  registered one-cycle pulse, one or more balls popped
popCount  out  CW  registered number of balls popped in that update; 0 when popValid=0
ballsRemaining  out  CW  registered population count of ballVisible
allCleared  out  1  high while in CLEARED state

Behaviour:
- Single clock domain. Reset is sampled on posedge clk only. While resetN=0: state=INACTIVE, ballVisible=0, popValid=0, popCount=0, ballsRemaining=0, allCleared=0.
- States: INACTIVE, DEPLOY, ACTIVE, CLEARED.
  - INACTIVE -> DEPLOY when unitActive=1.
  - DEPLOY -> ACTIVE unconditionally after 1 cycle.
  - ACTIVE -> INACTIVE when unitActive=0. This has priority over every other transition.
  - ACTIVE -> CLEARED when unitActive=1 and registered ballVisible==0.
  - CLEARED -> INACTIVE when unitActive=0.
- Visibility next-value:
  - INACTIVE and CLEARED: all zeros.
  - DEPLOY: only bit 0 set.
  - ACTIVE with unitActive=0: all zeros, popValid=0.
  - ACTIVE with unitActive=1: hit[i] = col_rope_ball_vec[i] & ballVisible[i]. Each hit ball clears bit i. If i < 2^(LEVELS-1)-1 (non-leaf), bits 2i+1 and 2i+2 are also set.
- All hits in one cycle are processed together; sibling and cousin hits are independent. A parent and its children are never visible at the same time, so no set/clear conflict exists. Should a set and a clear of the same bit coincide anyway, the clear wins.
- Rope or player collisions on invisible balls are ignored: no state change and no output assertion.
- Player collisions never change state. They are only forwarded, masked, to col_player_ball.
- Latency: a hit in cycle n updates ballVisible, popValid, popCount and ballsRemaining at edge n+1. When the last ball pops at edge n+1, allCleared rises at edge n+2.
- popCount is the number of set bits in hit; it is at most 2^(LEVELS-1) and fits CW. ballsRemaining is the population count of the next ballVisible, registered together with it.
- With LEVELS=1 there is only a root leaf. Hitting it clears it, then the block goes to CLEARED.
- unitActive held high in CLEARED keeps the block in CLEARED; the level does not re-deploy until unitActive is deasserted.

Test Plan:
(LEVELS=3)
1. Reset: resetN=0 for 2 cycles with random collision inputs -> all outputs 0. Release with unitActive=0 -> outputs stay 0.
2. Deploy: raise unitActive -> 1 cycle in DEPLOY, then ballVisible=7'b0000001 and ballsRemaining=1 on entering ACTIVE; popValid=0.
3. Split root: col_rope_ball_vec=7'b0000001 for 1 cycle -> col_rope_ball=1 in the same cycle. Next cycle: ballVisible=7'b0000110, popValid=1, popCount=1, ballsRemaining=2. popValid drops the following cycle.
4. Masking and simultaneous hits: col_rope_ball_vec=7'b0100000 (ball 5 invisible) -> col_rope_ball=0, no change. Then 7'b0000110 -> ballVisible=7'b1111000, popCount=2, ballsRemaining=4.
5. Clear: col_rope_ball_vec=7'b1111000 -> ballVisible=0, popCount=4, then allCleared=1 next cycle. Drop unitActive -> INACTIVE, allCleared=0.
6. Abort and reset mid-game:
   - In ACTIVE with ballVisible=7'b0000110, set unitActive=0 and a hit on ball 1 in the same cycle -> next cycle ballVisible=0, popValid=0, state INACTIVE.
   - Separately, resetN=0 for 1 cycle mid-ACTIVE -> all outputs 0 at the next edge.
